msg_stream_arbiter: RTL and testbench
=====================================

# msg_stream_arbiter

Packet-granular round-robin arbiter that shares the single 64-bit `message_extractor` input between NUM_SRC Avalon-ST packet sources. It holds a grant from a source's startofpacket beat through its endofpacket beat and tags the output with the source index. Beats that arrive outside any packet are drained. An optional watchdog terminates packets from a granted source that stalls. It sits directly upstream of the extractor, one instance per extractor.

## Interface

Parameters:
- NUM_SRC, 4: number of sources, legal range 2..16.
- TIMEOUT_CYC, 1024: consecutive idle cycles of the granted source before the watchdog fires. Used only with MSG_ARB_TIMEOUT_EN.
- CH_W, derived as clog2(NUM_SRC): width of out_channel. This is a localparam.

Ports:
- clk  in  1  rising-edge clock. This block has one clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- src_data  in  NUM_SRC*64  source i occupies bits [64i+63:64i].
- src_valid / src_startofpacket / src_endofpacket / src_error  in  NUM_SRC  one bit per source.
- src_empty  in  NUM_SRC*3  empty byte count per source.
- src_ready  out  NUM_SRC  per-source ready, ready latency 0.
- out_data  out  64  beat to the extractor.
- out_valid / out_startofpacket / out_endofpacket / out_error  out  1  beat qualifiers.
- out_empty  out  3  empty byte count.
- out_channel  out  CH_W  index of the granted source.
- out_ready  in  1  extractor ready (its in_ready).
- busy  out  1  high when state is not IDLE.
- orphan_drop  out  1  one-cycle pulse for each discarded orphan beat.
- timeout  out  1  one-cycle pulse when the watchdog fires.

## Operation

States: IDLE, BUSY, TERM, FLUSH.

- **IDLE**
  - Rotate from ptr and find the first i with src_valid[i] & src_startofpacket[i].
  - If found: register grant=i, go to BUSY. No beat transfers in this cycle.
  - Any source presenting valid without sop gets src_ready=1. Its beat is discarded and orphan_drop pulses once per cycle in which at least one such beat is discarded.
- **BUSY**
  - Pass-through: out_* = src_*[grant], out_valid = src_valid[grant], src_ready[grant] = out_ready. All other src_ready are 0.
  - A transfer occurs when out_valid & out_ready.
  - A transfer with eop set: ptr = grant+1 (mod NUM_SRC), go to IDLE.
- **TERM** (timeout build only)
  - Drive a synthetic beat: out_valid=1, sop=0, eop=1, error=1, data=0, empty=0. All src_ready are 0.
  - When out_ready: go to FLUSH.
- **FLUSH**
  - src_ready[grant]=1; beats are discarded and out_valid=0.
  - Discarding the eop beat: ptr = grant+1, go to IDLE.

Other rules:
- ptr is a CH_W-bit register. It wraps from NUM_SRC-1 to 0.
- out_channel equals grant in BUSY and TERM, and 0 otherwise.

## Timing

- Reset values:
  - state=IDLE, ptr=0, grant=0, watchdog counter=0.
  - out_valid=0, out_startofpacket=0, out_endofpacket=0, out_error=0, out_data=0, out_empty=0, out_channel=0.
  - src_ready=0, busy=0, orphan_drop=0, timeout=0.
- Reset mid-packet: return to IDLE immediately and drop the partial packet. The extractor is reset by the same reset.
- Data path latency is 0 cycles (combinational mux). Control is registered.
- Arbitration overhead is exactly 1 idle cycle between the eop transfer and the next sop transfer.
- A single-beat packet (sop & eop on the same beat) takes 1 BUSY cycle, then returns to IDLE.
- A new request arriving during the eop transfer cycle is not seen until the following IDLE cycle.
- Backpressure: out_ready low while out_valid is high holds every out_* signal stable.

## Configuration

- MSG_ARB_TIMEOUT_EN defined:
  - A 16-bit counter increments each BUSY cycle where src_valid[grant]=0, and clears on any cycle where it is 1.
  - Cycles stalled only by out_ready do not count.
  - When the counter reaches TIMEOUT_CYC-1: timeout pulses, go to TERM.
- MSG_ARB_TIMEOUT_EN undefined: TERM and FLUSH are unreachable, timeout is tied to 0, and BUSY waits indefinitely.

## Structure

- Package msg_arb_pkg holds:
  - the state enum (IDLE, BUSY, TERM, FLUSH);
  - BEAT_W=64 and EMPTY_W=3;
  - the synthetic terminate-beat constants.
- Sub-module rr_pick: a combinational rotate-priority encoder taking (req[NUM_SRC], ptr) and returning (found, idx).

## Test plan

- **Round robin:** sources 0 and 2 each hold a 3-beat packet at reset release → grant 0 (beats on channel 0), 1 idle cycle, grant 2. Next contention between 0 and 2 grants 0 again, because ptr=3 wraps to 0.
- **Backpressure:** out_ready toggles every cycle during a 5-beat packet from source 1 → 5 transfers, each out_data stable while stalled, out_channel=1.
- **Orphan beat:** source 3 presents valid without sop while IDLE → src_ready[3]=1, orphan_drop pulses for 1 cycle, nothing appears on out_*.
- **Timeout** (TIMEOUT_CYC=8): source 0 stops after 2 of 4 beats → timeout pulses on the 8th idle cycle, then a synthetic beat with eop=1, error=1, data=0. The remaining beats are flushed and the next packet is granted.
- **Reset mid-packet:** reset asserted on beat 2 of 4 → the next cycle shows state IDLE, out_valid=0, src_ready=0, and the first grant after reset is source 0.

Source files
------------

// File: rtl/msg_arb_pkg.sv
// msg_stream_arbiter shared types: FSM states, beat widths,
// synthetic terminate beat, pointer wrap helper.
package msg_arb_pkg;

  localparam int BEAT_W  = 64;
  localparam int EMPTY_W = 3;
  localparam int WD_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    TERM,
    FLUSH
  } arb_state_e;

  localparam logic [BEAT_W-1:0]  TERM_DATA  = '0;
  localparam logic [EMPTY_W-1:0] TERM_EMPTY = '0;
  localparam logic               TERM_SOP   = 1'b0;
  localparam logic               TERM_EOP   = 1'b1;
  localparam logic               TERM_ERR   = 1'b1;

  function automatic int unsigned wrap_inc(
    input int unsigned cur,
    input int unsigned n
  );
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/msg_stream_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] cand;

  // scan from farthest to nearest so the nearest hit wins
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = W'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/msg_stream_arbiter.sv
// Packet-granular round-robin arbiter in front of message_extractor.
// Optional stall watchdog: define MSG_ARB_TIMEOUT_EN.
module msg_stream_arbiter
  import msg_arb_pkg::*;
#(
  parameter  int NUM_SRC     = 4,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int CH_W        = $clog2(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC*BEAT_W-1:0]  src_data,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC-1:0]         src_startofpacket,
  input  logic [NUM_SRC-1:0]         src_endofpacket,
  input  logic [NUM_SRC-1:0]         src_error,
  input  logic [NUM_SRC*EMPTY_W-1:0] src_empty,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic [BEAT_W-1:0]          out_data,
  output logic                       out_valid,
  output logic                       out_startofpacket,
  output logic                       out_endofpacket,
  output logic                       out_error,
  output logic [EMPTY_W-1:0]         out_empty,
  output logic [CH_W-1:0]            out_channel,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       orphan_drop,
  output logic                       timeout
);

  arb_state_e state_q, state_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] grant_nxt;

  logic [NUM_SRC-1:0] sop_req;
  logic [NUM_SRC-1:0] orphan;
  logic               pick_found;
  logic [CH_W-1:0]    pick_idx;

  logic [BEAT_W-1:0]  data_a  [NUM_SRC];
  logic [EMPTY_W-1:0] empty_a [NUM_SRC];

  logic               g_valid;
  logic               g_sop;
  logic               g_eop;
  logic               g_err;
  logic [BEAT_W-1:0]  g_data;
  logic [EMPTY_W-1:0] g_empty;

  logic wd_fire;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign data_a[i]  = src_data[i*BEAT_W +: BEAT_W];
    assign empty_a[i] = src_empty[i*EMPTY_W +: EMPTY_W];
  end

  assign sop_req   = src_valid & src_startofpacket;
  assign orphan    = src_valid & ~src_startofpacket;
  assign grant_nxt = CH_W'(wrap_inc(32'(grant_q), NUM_SRC));

  assign g_valid = src_valid[grant_q];
  assign g_sop   = src_startofpacket[grant_q];
  assign g_eop   = src_endofpacket[grant_q];
  assign g_err   = src_error[grant_q];
  assign g_data  = data_a[grant_q];
  assign g_empty = empty_a[grant_q];

  rr_pick #(
    .N (NUM_SRC),
    .W (CH_W)
  ) u_pick (
    .req_i   (sop_req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

`ifdef MSG_ARB_TIMEOUT_EN
  logic [WD_W-1:0] wd_q, wd_d;

  // count granted-source idle cycles; backpressure alone does not count
  always_comb begin
    wd_d    = '0;
    wd_fire = 1'b0;
    if (state_q == BUSY && !g_valid) begin
      if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
        wd_fire = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  // watchdog counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // next state, grant/pointer update and all handshake outputs
  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    grant_d           = grant_q;
    src_ready         = '0;
    out_valid         = 1'b0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    out_error         = 1'b0;
    out_data          = '0;
    out_empty         = '0;
    out_channel       = '0;
    busy              = 1'b0;
    orphan_drop       = 1'b0;
    timeout           = 1'b0;
    if (!reset) begin
      busy = (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          src_ready   = orphan;
          orphan_drop = |orphan;
          if (pick_found) begin
            grant_d = pick_idx;
            state_d = BUSY;
          end
        end
        BUSY: begin
          out_valid          = g_valid;
          out_startofpacket  = g_sop;
          out_endofpacket    = g_eop;
          out_error          = g_err;
          out_data           = g_data;
          out_empty          = g_empty;
          out_channel        = grant_q;
          src_ready[grant_q] = out_ready;
          if (g_valid && out_ready && g_eop) begin
            ptr_d   = grant_nxt;
            state_d = IDLE;
          end else if (wd_fire) begin
            timeout = 1'b1;
            state_d = TERM;
          end
        end
        TERM: begin
          out_valid         = 1'b1;
          out_startofpacket = TERM_SOP;
          out_endofpacket   = TERM_EOP;
          out_error         = TERM_ERR;
          out_data          = TERM_DATA;
          out_empty         = TERM_EMPTY;
          out_channel       = grant_q;
          if (out_ready) begin
            state_d = FLUSH;
          end
        end
        FLUSH: begin
          src_ready[grant_q] = 1'b1;
          if (g_valid && g_eop) begin
            ptr_d   = grant_nxt;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// Scoreboard bench for msg_stream_arbiter.
// Timeout scenario runs when MSG_ARB_TIMEOUT_EN is defined.
module tb_msg_stream_arbiter;

  localparam int NS  = 4;
  localparam int TO  = 8;
  localparam int CW  = 2;
  localparam int SNW = 64 + 3 + 3 + CW;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS*64-1:0]  src_data;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_startofpacket;
  logic [NS-1:0]     src_endofpacket;
  logic [NS-1:0]     src_error;
  logic [NS*3-1:0]   src_empty;
  logic [NS-1:0]     src_ready;
  logic [63:0]       out_data;
  logic              out_valid;
  logic              out_startofpacket;
  logic              out_endofpacket;
  logic              out_error;
  logic [2:0]        out_empty;
  logic [CW-1:0]     out_channel;
  logic              out_ready;
  logic              busy;
  logic              orphan_drop;
  logic              timeout;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic        err;
    logic [2:0]  empty;
    logic        stop;
  } sbeat_t;

  typedef struct {
    logic [63:0]   data;
    logic          sop;
    logic          eop;
    logic          err;
    logic [2:0]    empty;
    logic [CW-1:0] ch;
  } ebeat_t;

  sbeat_t        srcq [NS][$];
  ebeat_t        expq [$];
  logic [NS-1:0] hold;
  logic [NS-1:0] drv_hs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfers = 0;
  int orph_cnt = 0;
  int to_cnt = 0;
  int to_cyc = 0;
  int stall_chk = 0;
  int sop_cyc [NS];
  int eop_cyc [NS];
  int last_cyc [NS];

  msg_stream_arbiter #(
    .NUM_SRC     (NS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_startofpacket (src_startofpacket),
    .src_endofpacket   (src_endofpacket),
    .src_error         (src_error),
    .src_empty         (src_empty),
    .src_ready         (src_ready),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_error         (out_error),
    .out_empty         (out_empty),
    .out_channel       (out_channel),
    .out_ready         (out_ready),
    .busy              (busy),
    .orphan_drop       (orphan_drop),
    .timeout           (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic int pending();
    int n = expq.size();
    for (int i = 0; i < NS; i++) n += srcq[i].size();
    return n;
  endfunction

  function automatic logic [SNW-1:0] evec(input ebeat_t e);
    return {e.data, e.sop, e.eop, e.err, e.empty, e.ch};
  endfunction

  function automatic logic [SNW-1:0] ovec();
    return {out_data, out_startofpacket, out_endofpacket,
            out_error, out_empty, out_channel};
  endfunction

  task automatic drive(input int i);
    if (srcq[i].size() > 0 && !hold[i]) begin
      src_valid[i]           = 1'b1;
      src_startofpacket[i]   = srcq[i][0].sop;
      src_endofpacket[i]     = srcq[i][0].eop;
      src_error[i]           = srcq[i][0].err;
      src_data[i*64 +: 64]   = srcq[i][0].data;
      src_empty[i*3 +: 3]    = srcq[i][0].empty;
    end else begin
      src_valid[i]           = 1'b0;
      src_startofpacket[i]   = 1'b0;
      src_endofpacket[i]     = 1'b0;
      src_error[i]           = 1'b0;
      src_data[i*64 +: 64]   = '0;
      src_empty[i*3 +: 3]    = '0;
    end
  endtask

  task automatic send_pkt(input int s, input int n, input int seq,
                          input int stop_at, input int n_exp,
                          input logic err_last);
    for (int b = 0; b < n; b++) begin
      sbeat_t sb;
      ebeat_t eb;
      sb.data  = {4'hA, 4'(s), 8'(seq), 16'hBEEF, 32'(b + 1)};
      sb.sop   = (b == 0);
      sb.eop   = (b == n - 1);
      sb.err   = err_last && (b == n - 1);
      sb.empty = (b == n - 1) ? 3'(s + 1) : 3'd0;
      sb.stop  = (b + 1 == stop_at);
      srcq[s].push_back(sb);
      if (b < n_exp) begin
        eb.data  = sb.data;
        eb.sop   = sb.sop;
        eb.eop   = sb.eop;
        eb.err   = sb.err;
        eb.empty = sb.empty;
        eb.ch    = CW'(s);
        expq.push_back(eb);
      end
    end
  endtask

  task automatic push_orphan(input int s);
    sbeat_t sb;
    sb.data  = 64'hDEAD_0000_0000_0003;
    sb.sop   = 1'b0;
    sb.eop   = 1'b0;
    sb.err   = 1'b0;
    sb.empty = 3'd0;
    sb.stop  = 1'b0;
    srcq[s].push_back(sb);
  endtask

  task automatic push_term(input int s);
    ebeat_t eb;
    eb.data  = 64'h0;
    eb.sop   = 1'b0;
    eb.eop   = 1'b1;
    eb.err   = 1'b1;
    eb.empty = 3'd0;
    eb.ch    = CW'(s);
    expq.push_back(eb);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while ((pending() != 0 || busy) && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (pending() != 0 || busy) begin
      errors++;
      $display("FAIL %s drain: pending=%0d busy=%0b required 0/0",
               nm, pending(), busy);
    end
  endtask

  // source driver: retire handshaken beats, present the next one
  initial begin
    src_valid         = '0;
    src_startofpacket = '0;
    src_endofpacket   = '0;
    src_error         = '0;
    src_data          = '0;
    src_empty         = '0;
    hold              = '0;
    forever begin
      @(posedge clk);
      drv_hs = src_valid & src_ready;
      #1;
      for (int i = 0; i < NS; i++) begin
        if (drv_hs[i] && srcq[i].size() > 0) begin
          if (srcq[i][0].stop) hold[i] = 1'b1;
          void'(srcq[i].pop_front());
        end
        drive(i);
      end
    end
  end

  // monitor: scoreboard compare, stall stability, pulse counters
  initial begin
    ebeat_t         e;
    logic           stl;
    logic [SNW-1:0] snap;
    int             ch;
    stl  = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (stl) begin
        checks++;
        stall_chk++;
        if (!out_valid || ovec() != snap) begin
          errors++;
          $display("FAIL hold_stable actual=%0b/%h required=1/%h",
                   out_valid, ovec(), snap);
        end
      end
      stl  = out_valid && !out_ready;
      snap = ovec();
      if (orphan_drop) orph_cnt++;
      if (timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        checks++;
        xfers++;
        ch = int'(out_channel);
        last_cyc[ch] = cyc;
        if (out_startofpacket) sop_cyc[ch] = cyc;
        if (out_endofpacket) eop_cyc[ch] = cyc;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%h required=none",
                   ovec());
        end else begin
          e = expq.pop_front();
          if (ovec() !== evec(e)) begin
            errors++;
            $display("FAIL beat actual=%h required=%h",
                     ovec(), evec(e));
          end
        end
      end
    end
  end

  initial begin
    int k;
    int x0;
    int o0;
    int s0;
`ifdef MSG_ARB_TIMEOUT_EN
    int t0;
`endif
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sop", 64'(out_startofpacket), 64'd0);
    chk("rst_out_eop", 64'(out_endofpacket), 64'd0);
    chk("rst_out_err", 64'(out_error), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_empty", 64'(out_empty), 64'd0);
    chk("rst_out_channel", 64'(out_channel), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_orphan", 64'(orphan_drop), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);

    // round robin: 0 then 2, one idle cycle between
    send_pkt(0, 3, 1, 0, 3, 1'b0);
    send_pkt(2, 3, 1, 0, 3, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    wait_idle("rr1", 100);
    chk("rr1_gap", 64'(sop_cyc[2] - eop_cyc[0]), 64'd2);

    // ptr now 3 -> wraps, source 0 wins again
    @(negedge clk);
    #1;
    send_pkt(0, 2, 2, 0, 2, 1'b0);
    send_pkt(2, 2, 2, 0, 2, 1'b1);
    wait_idle("rr2", 100);
    chk("rr2_gap", 64'(sop_cyc[2] - eop_cyc[0]), 64'd2);

    // backpressure on a 5-beat packet from source 1
    x0 = xfers;
    s0 = stall_chk;
    send_pkt(1, 5, 3, 0, 5, 1'b0);
    k = 0;
    while ((pending() != 0 || busy) && k < 100) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
      k++;
    end
    out_ready = 1'b1;
    wait_idle("bp", 50);
    chk("bp_xfers", 64'(xfers - x0), 64'd5);
    chk("bp_stalls_seen", 64'(stall_chk > s0), 64'd1);

    // orphan beat on source 3 while idle
    @(negedge clk);
    #1;
    o0 = orph_cnt;
    push_orphan(3);
    @(negedge clk);
    #1;
    chk("orphan_ready", 64'(src_ready[3]), 64'd1);
    chk("orphan_pulse", 64'(orphan_drop), 64'd1);
    chk("orphan_no_out", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("orphan_pulse_end", 64'(orphan_drop), 64'd0);
    chk("orphan_count", 64'(orph_cnt - o0), 64'd1);

    // reset on beat 2 of a 4-beat packet from source 1
    x0 = xfers;
    send_pkt(1, 4, 4, 0, 1, 1'b0);
    k = 0;
    while (xfers == x0 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("rst_mid_beat1", 64'(xfers - x0), 64'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < NS; i++) srcq[i].delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_src_ready", 64'(src_ready), 64'd0);
    send_pkt(0, 2, 5, 0, 2, 1'b0);
    send_pkt(2, 2, 5, 0, 2, 1'b0);
    wait_idle("rst_regrant", 100);

`ifdef MSG_ARB_TIMEOUT_EN
    // source 0 stalls after 2 of 4 beats
    @(negedge clk);
    #1;
    t0 = to_cnt;
    send_pkt(0, 4, 6, 2, 2, 1'b0);
    push_term(0);
    send_pkt(1, 2, 6, 0, 2, 1'b0);
    k = 0;
    while (to_cnt == t0 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("to_fired", 64'(to_cnt - t0), 64'd1);
    chk("to_latency", 64'(to_cyc - last_cyc[0]), 64'(TO));
    hold[0] = 1'b0;
    wait_idle("timeout", 200);
    chk("to_single_pulse", 64'(to_cnt - t0), 64'd1);
`else
    chk("no_timeout", 64'(to_cnt), 64'd0);
`endif

    repeat (2) @(negedge clk);
    #1;
    chk("exp_empty", 64'(expq.size()), 64'd0);
    chk("orphan_total", 64'(orph_cnt), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
